// File: rtl/mem_access_arbiter_if.sv
// Requester, grant and memory-side signals of the
// two-port memory access arbiter.
interface mem_access_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64
);
  logic                    if_req_i;
  logic [MEMORY_DEPTH-1:0] if_addr_i;
  logic                    if_gnt_o;
  logic                    if_rvalid_o;
  logic [DATA_WIDTH-1:0]   if_rdata_o;

  logic                    d_req_i;
  logic                    d_we_i;
  logic [MEMORY_DEPTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0]   d_wdata_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [DATA_WIDTH-1:0]   d_rdata_o;

  logic [MEMORY_DEPTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Fetch/data arbiter onto one single-cycle memory port,
// data-first with a starvation escape for fetch.
module mem_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter int MAX_WAIT     = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_access_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    D_RD,
    D_WR
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_wait;
  logic [3:0]              w_wait_nxt;
  logic                    w_force;
  logic                    w_if_gnt;
  logic                    w_d_gnt;
  logic                    w_if_rv;
  logic                    w_d_rv;
  logic [MEMORY_DEPTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic                    w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Grants are gated by rst_n so nothing leaks out while held in reset.
  assign w_force  = (r_wait == LP_MAX);
  assign w_if_gnt = rst_n & bus.if_req_i
                  & (~bus.d_req_i | w_force);
  assign w_d_gnt  = rst_n & bus.d_req_i & ~w_if_gnt;

  always_comb begin
    w_state_nxt = IDLE;
    w_addr      = '0;
    w_wdata     = '0;
    w_we        = 1'b0;
    unique case (1'b1)
      w_if_gnt: begin
        w_addr      = bus.if_addr_i;
        w_state_nxt = IF_RD;
      end
      w_d_gnt: begin
        w_addr      = bus.d_addr_i;
        w_wdata     = bus.d_wdata_i;
        w_we        = bus.d_we_i;
        w_state_nxt = bus.d_we_i ? D_WR : D_RD;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wait_nxt = 4'd0;
    if (bus.if_req_i && !w_if_gnt) begin
      w_wait_nxt = w_force ? r_wait : r_wait + 4'd1;
    end
  end

  assign w_if_rv = rst_n & (r_state == IF_RD);
  assign w_d_rv  = rst_n & (r_state == D_RD);

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.d_gnt_o     = w_d_gnt;
  assign bus.mem_addr_o  = w_addr;
  assign bus.mem_wdata_o = w_wdata;
  assign bus.mem_we_o    = w_we;
  assign bus.if_rvalid_o = w_if_rv;
  assign bus.d_rvalid_o  = w_d_rv;
  assign bus.if_rdata_o  = w_if_rv ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = w_d_rv ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: stimulus pushes
// expected grants/read returns, a negedge monitor checks them.
module tb_mem_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 64;

  typedef struct {
    int          cyc;
    logic        ig;
    logic        dg;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wd;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic        iv;
    logic        dv;
    logic [31:0] rd;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;
  gexp_t       gq[$];
  rexp_t       rq[$];
  gexp_t       g_h;
  rexp_t       r_h;
  logic [63:0] r_rd_addr = '0;
  logic [5:0]  both_if;

  always #5 clk = ~clk;

  mem_access_arbiter_if #(
    .DATA_WIDTH(DW),
    .MEMORY_DEPTH(AW)
  ) bus ();

  mem_access_arbiter #(
    .DATA_WIDTH(DW),
    .MEMORY_DEPTH(AW),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Memory model: synchronous read of a fixed address pattern.
  always @(posedge clk) r_rd_addr <= bus.mem_addr_o;
  assign bus.mem_rdata_i = 32'hA500_0000 ^ r_rd_addr[31:0];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [63:0] a);
    return 32'hA500_0000 ^ a[31:0];
  endfunction

  task automatic drive(
    input logic        ireq,
    input logic [63:0] iaddr,
    input logic        dreq,
    input logic        dwe,
    input logic [63:0] daddr,
    input logic [31:0] dwd
  );
    bus.if_req_i  = ireq;
    bus.if_addr_i = iaddr;
    bus.d_req_i   = dreq;
    bus.d_we_i    = dwe;
    bus.d_addr_i  = daddr;
    bus.d_wdata_i = dwd;
  endtask

  task automatic step(
    input logic        ireq,
    input logic [63:0] iaddr,
    input logic        dreq,
    input logic        dwe,
    input logic [63:0] daddr,
    input logic [31:0] dwd,
    input logic        eig,
    input logic        edg,
    input logic        push_rv
  );
    gexp_t g;
    rexp_t r;
    @(posedge clk);
    #1;
    drive(ireq, iaddr, dreq, dwe, daddr, dwd);
    g.cyc  = cyc;
    g.ig   = eig;
    g.dg   = edg;
    g.we   = edg & dwe;
    g.addr = eig ? iaddr : (edg ? daddr : 64'h0);
    g.wd   = edg ? dwd : 32'h0;
    gq.push_back(g);
    if (push_rv && (eig || (edg && !dwe))) begin
      r.cyc = cyc + 1;
      r.iv  = eig;
      r.dv  = edg;
      r.rd  = eig ? pat(iaddr) : pat(daddr);
      rq.push_back(r);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (bus.if_gnt_o || bus.d_gnt_o || bus.mem_we_o
          || bus.if_rvalid_o || bus.d_rvalid_o
          || bus.mem_addr_o != 0 || bus.mem_wdata_o != 0
          || bus.if_rdata_o != 0 || bus.d_rdata_o != 0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b%b rv=%b%b we=%b addr=%h wd=%h want all 0",
                 cyc, bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o,
                 bus.d_rvalid_o, bus.mem_we_o, bus.mem_addr_o,
                 bus.mem_wdata_o);
      end
    end else begin
      checks++;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g_h = gq.pop_front();
        if (bus.if_gnt_o !== g_h.ig || bus.d_gnt_o !== g_h.dg
            || bus.mem_we_o !== g_h.we
            || bus.mem_addr_o !== g_h.addr
            || bus.mem_wdata_o !== g_h.wd) begin
          errors++;
          $display("FAIL grant cyc=%0d got ig=%b dg=%b we=%b addr=%h wd=%h want ig=%b dg=%b we=%b addr=%h wd=%h",
                   cyc, bus.if_gnt_o, bus.d_gnt_o, bus.mem_we_o,
                   bus.mem_addr_o, bus.mem_wdata_o, g_h.ig, g_h.dg,
                   g_h.we, g_h.addr, g_h.wd);
        end
      end else if (bus.if_gnt_o || bus.d_gnt_o || bus.mem_we_o
                   || bus.mem_addr_o != 0
                   || bus.mem_wdata_o != 0) begin
        errors++;
        $display("FAIL idle_bus cyc=%0d got ig=%b dg=%b we=%b addr=%h wd=%h want all 0",
                 cyc, bus.if_gnt_o, bus.d_gnt_o, bus.mem_we_o,
                 bus.mem_addr_o, bus.mem_wdata_o);
      end
      checks++;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r_h = rq.pop_front();
        if (bus.if_rvalid_o !== r_h.iv || bus.d_rvalid_o !== r_h.dv
            || bus.if_rdata_o !== (r_h.iv ? r_h.rd : 32'h0)
            || bus.d_rdata_o !== (r_h.dv ? r_h.rd : 32'h0)) begin
          errors++;
          $display("FAIL rvalid cyc=%0d got iv=%b dv=%b ird=%h drd=%h want iv=%b dv=%b rd=%h",
                   cyc, bus.if_rvalid_o, bus.d_rvalid_o,
                   bus.if_rdata_o, bus.d_rdata_o,
                   r_h.iv, r_h.dv, r_h.rd);
        end
      end else if (bus.if_rvalid_o || bus.d_rvalid_o
                   || bus.if_rdata_o != 0
                   || bus.d_rdata_o != 0) begin
        errors++;
        $display("FAIL no_rvalid cyc=%0d got iv=%b dv=%b ird=%h drd=%h want all 0",
                 cyc, bus.if_rvalid_o, bus.d_rvalid_o,
                 bus.if_rdata_o, bus.d_rdata_o);
      end
    end
    if (done) begin
      checks++;
      if (gq.size() != 0 || rq.size() != 0) begin
        errors++;
        $display("FAIL leftover got gq=%0d rq=%0d want 0 0",
                 gq.size(), rq.size());
      end
    end
  end

  initial begin
    drive(1, 64'h8, 1, 1, 64'hC, 32'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    step(1, 64'h4, 0, 0, 0, 0, 1, 0, 1);
    idle();
    step(0, 0, 1, 1, 64'h10, 32'hCAFE_0001, 0, 1, 1);
    idle();

    both_if = 6'b01_0000;
    for (int i = 0; i < 6; i++) begin
      step(1, 64'h20, 1, 0, 64'h30, 0,
           both_if[i], !both_if[i], 1);
    end
    idle();

    step(1, 64'h40, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 64'h44, 0, 0, 1, 1);
    step(1, 64'h48, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 64'h4C, 0, 0, 1, 1);
    idle();

    for (int i = 0; i < 3; i++) begin
      step(1, 64'h80, 1, 0, 64'h90, 0, 0, 1, 1);
    end
    step(0, 0, 1, 1, 64'h94, 32'h5555_AAAA, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 64'h84, 1, 0, 64'h98, 0, i == 4, i != 4, 1);
    end
    idle();

    // Data read granted, then reset lands mid-way through its return cycle.
    step(0, 0, 1, 0, 64'h50, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    drive(1, 64'h60, 1, 0, 64'h64, 0);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) idle();
    step(1, 64'h70, 0, 0, 0, 0, 1, 0, 1);
    idle();
    idle();

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
